pwm_dac_multi: RTL
==================

Name: pwm_dac_multi

Overview:
- Multi-channel, parametrised PWM DAC for the audio output path.
- Takes one frame of NCH samples through a valid/ready handshake and double-buffers it.
- Drives one PWM bit per channel from a single free-running internal carrier counter.
- Differs from the earlier single-channel 4-bit PWM stage:
  - the carrier counter is internal rather than supplied externally;
  - sample updates are glitch-free, applied only at period boundaries;
  - signed (two's complement) input is supported;
  - sample underrun is detected.

Parameters:
- NCH, 2, number of output channels (1..8).
- WIDTH, 8, sample width in bits; the PWM period is 2^WIDTH MCLK cycles (WIDTH 3..12).
- SIGNED_IN, 1, 1 = din is two's complement (offset-binary converted); 0 = din is unsigned duty.

Ports:
- MCLK  in  1  system clock.
- MRST  in  1  synchronous active-high reset.
- en  in  1  carrier enable.
- din  in  NCH*WIDTH  sample frame; channel i occupies bits [i*WIDTH +: WIDTH].
- din_valid  in  1  frame valid.
- din_ready  out  1  shadow buffer empty; frame accepted when din_valid && din_ready.
- clr_underrun  in  1  clears the sticky underrun flag.
- dout  out  NCH  registered PWM outputs.
- period_start  out  1  one-cycle pulse marking the first output cycle of each period.
- underrun  out  1  sticky flag: a period boundary passed with no new frame.

Behaviour:
- Reset values: cnt=0, shadow empty, din_ready=1, armed=0, dout=0, period_start=0, underrun=0.
- Reset value of active[i]: 2^(WIDTH-1) when SIGNED_IN=1 (midscale, i.e. silence); 0 when SIGNED_IN=0.
- MRST mid-period: all state returns to reset values on the next edge; any shadow frame is discarded.
- Duty conversion: duty = din_ch with its MSB inverted if SIGNED_IN, else din_ch unchanged. Example: WIDTH=8, -128 -> 0, 0 -> 128, +127 -> 255.
- Carrier: WIDTH-bit counter cnt. When en=1 it increments each cycle and wraps 2^WIDTH-1 -> 0. When en=0 it is held at 0.
- Compare: dout[i] <= en && (cnt < active[i]), unsigned compare.
  - dout lags cnt by exactly one cycle.
  - duty 0 gives constant low; duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
- period_start <= en && (cnt == 0), so it is aligned with the first dout cycle of the period.
- Handshake:
  - din_ready = !shadow_full, combinational from a register.
  - On accept, the shadow captures the converted frame, shadow_full is set, and armed is set.
  - din_valid is ignored while din_ready=0; din may change freely when not accepted.
- Boundary transfer, in the cycle where en=1 and cnt == 2^WIDTH-1:
  - If shadow_full: active <= shadow and shadow_full is cleared.
  - Else: active holds its value, and underrun is set if armed.
- Latency: a frame accepted during period k is applied from the first dout cycle of period k+1.
- Simultaneous events:
  - Accept in the wrap cycle with the shadow empty: the frame enters the shadow only. It does not transfer in that cycle and applies one period later.
  - Underrun set and clr_underrun in the same cycle: set wins.
- en=0:
  - dout=0 and period_start=0.
  - The handshake keeps operating; a full shadow transfers to active on the next edge, with no boundary wait.
  - Underrun detection is suspended.
- en rising: the carrier starts at cnt=0 with the current active values; the first period_start occurs one cycle later.

Decomposition:
- Shared package pwm_pkg:
  - function to_duty(din, signed_in): MSB inversion;
  - localparam CNT_MAX = 2^WIDTH-1;
  - constant MIDSCALE.
- Natural sub-module: pwm_compare_ch, one per channel via generate. It holds active[i] and dout[i], and takes cnt, load, and the shadow slice.
- The top level owns the counter, shadow/handshake, period_start and underrun logic.

Test Plan (WIDTH=4, NCH=2):
- Reset then en=1, no input, SIGNED_IN=1:
  - both dout high for 8 of every 16 cycles;
  - period_start every 16 cycles;
  - underrun stays 0 (not armed).
- Accept din={ch1=4'h7, ch0=4'h8} mid-period:
  - din_ready falls the next cycle;
  - from the next period_start, ch0 is low all period and ch1 is high 15/16;
  - din_ready returns to 1 after the wrap.
- Send one frame, then none: at the second wrap underrun=1 and stays set. clr_underrun pulse -> 0. clr_underrun asserted on the wrap cycle -> underrun stays 1.
- Accept a frame exactly on the cnt=15 cycle with the shadow empty: the frame is not applied in the next period; it is applied in the one after.
- SIGNED_IN=0, din ch0=0 and ch1=15: ch0 constant 0; ch1 low only on the cycle following cnt=15. Assert MRST mid-period: all outputs are 0 the next cycle and din_ready=1.
- en=0 with a frame accepted: shadow loads into active within 2 cycles, dout stays 0. Raising en gives period_start one cycle later.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and duty helpers for the multi-channel PWM DAC
package pwm_pkg;

    localparam int MAX_WIDTH = 12;

    // Top code of a WIDTH-bit carrier (last cycle of a period).
    function automatic logic [MAX_WIDTH-1:0] cnt_max(input int width);
        return MAX_WIDTH'((1 << width) - 1);
    endfunction

    // Half-scale code; silence for offset-binary samples.
    function automatic logic [MAX_WIDTH-1:0] midscale(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

    // Two's complement to offset binary is just an MSB flip.
    function automatic logic [MAX_WIDTH-1:0] to_duty(input logic [MAX_WIDTH-1:0] din,
                                                     input int width,
                                                     input bit signed_in);
        return din ^ (signed_in ? midscale(width) : '0);
    endfunction

endpackage

// File: rtl/pwm_dac_multi_compare_ch.sv
// rtl/pwm_dac_multi_compare_ch.sv - per-channel active duty register and PWM comparator
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic             load,
    input  logic [WIDTH-1:0] shadow,
    output logic             dout
);

    logic [WIDTH-1:0] active;

    // Duty takes effect only on load; output is the registered carrier compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= RESET_VAL;
            dout   <= 1'b0;
        end else begin
            if (load) begin
                active <= shadow;
            end
            dout <= en && (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_dac_multi.sv
// rtl/pwm_dac_multi.sv - multi-channel double-buffered PWM DAC with underrun detection
module pwm_dac_multi
    import pwm_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int WIDTH     = 8,
    parameter int SIGNED_IN = 1
) (
    input  logic                 MCLK,
    input  logic                 MRST,
    input  logic                 en,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 clr_underrun,
    output logic [NCH-1:0]       dout,
    output logic                 period_start,
    output logic                 underrun
);

    localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(cnt_max(WIDTH));
    localparam logic [WIDTH-1:0] ACTIVE_RST = (SIGNED_IN != 0) ? WIDTH'(midscale(WIDTH)) : '0;

    logic [WIDTH-1:0]     cnt;
    logic [NCH*WIDTH-1:0] shadow;
    logic [NCH*WIDTH-1:0] duty;
    logic                 shadow_full;
    logic                 armed;
    logic                 wrap;
    logic                 accept;
    logic                 load;

    assign din_ready = !shadow_full;
    assign accept    = din_valid && !shadow_full;
    assign wrap      = en && (cnt == CNT_MAX);
    // While stopped there is no period to wait for, so a pending frame loads at once.
    assign load      = shadow_full && (wrap || !en);

    // Per-channel sample to duty conversion of the incoming frame.
    always_comb begin
        duty = '0;
        for (int i = 0; i < NCH; i++) begin
            duty[i*WIDTH +: WIDTH] = WIDTH'(to_duty(MAX_WIDTH'(din[i*WIDTH +: WIDTH]),
                                                    WIDTH, SIGNED_IN != 0));
        end
    end

    // Carrier, shadow handshake, period marker and sticky underrun.
    always_ff @(posedge MCLK) begin
        if (MRST) begin
            cnt          <= '0;
            shadow       <= '0;
            shadow_full  <= 1'b0;
            armed        <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            cnt          <= en ? cnt + 1'b1 : '0;
            period_start <= en && (cnt == '0);
            if (accept) begin
                shadow      <= duty;
                shadow_full <= 1'b1;
                armed       <= 1'b1;
            end else if (load) begin
                shadow_full <= 1'b0;
            end
            // A fresh underrun outranks a simultaneous clear.
            if (wrap && !shadow_full && armed) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_compare_ch #(
            .WIDTH     (WIDTH),
            .RESET_VAL (ACTIVE_RST)
        ) u_ch (
            .clk    (MCLK),
            .rst    (MRST),
            .en     (en),
            .cnt    (cnt),
            .load   (load),
            .shadow (shadow[i*WIDTH +: WIDTH]),
            .dout   (dout[i])
        );
    end

endmodule
